cpu_node: RTL and testbench

CPU_NODE -- requirements
Module: cpu_node

---
 rtl/cpu_node.sv | 172 +++++++++++++++++
 tb/tb_cpu_node.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_node.sv
// Small CPU node: one-cycle ALU plus a direct-mapped, write-through, no-allocate
// one-word-per-line cache that reaches memory through an arbitrated bus.
//
// state  | meaning
// IDLE   | waiting for start_op; operands latched on request
// EXEC   | single-cycle ALU evaluation
// LOOKUP | cache index/tag compare for LOAD/STORE
// ARB    | req_arb held until gnt_arb
// BUS    | mem_req held until mem_ack (ack on entry accepted)
// DONE   | end_op pulse, result stable
module cpu_node #(
  parameter int DW = 8,
  parameter int AW = 12,
  parameter int LW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   A,
  input  logic [DW-1:0]   B,
  input  logic            start_op,
  input  logic [2:0]      op_sel,
  input  logic [AW-1:0]   address_in,
  input  logic [DW-1:0]   data_in,
  output logic            req_arb,
  input  logic            gnt_arb,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic            mem_we,
  output logic            mem_req,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ack,
  output logic [2*DW-1:0] result,
  output logic            end_op,
  output logic            hit
);

  localparam int NL = 1 << LW;
  localparam int TW = AW - LW;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_MUL   = 3'd2;
  localparam logic [2:0] OP_AND   = 3'd3;
  localparam logic [2:0] OP_OR    = 3'd4;
  localparam logic [2:0] OP_XOR   = 3'd5;
  localparam logic [2:0] OP_LOAD  = 3'd6;
  localparam logic [2:0] OP_STORE = 3'd7;

  typedef enum logic [2:0] {IDLE, EXEC, LOOKUP, ARB, BUS, DONE} state_t;

  state_t              state_q, state_d;
  logic [DW-1:0]       a_q, b_q, wdata_q;
  logic [2:0]          op_q;
  logic [AW-1:0]       addr_q;
  logic [2*DW-1:0]     result_q, result_d;
  logic                hit_q, hit_d;
  logic [NL-1:0]       valid_q, valid_d;
  logic [TW-1:0]       tag_mem [NL];
  logic [DW-1:0]       data_mem [NL];

  logic [LW-1:0]       idx;
  logic [TW-1:0]       tag;
  logic                lookup_hit;
  logic                fill_we, line_wr;
  logic [DW-1:0]       line_wdata;
  logic [DW-1:0]       diff;
  logic [DW:0]         sum;
  logic [2*DW-1:0]     alu_res;

  assign idx        = addr_q[LW-1:0];
  assign tag        = addr_q[AW-1:LW];
  assign lookup_hit = valid_q[idx] && (tag_mem[idx] == tag);

  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = a_q - b_q;
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = {{(DW-1){1'b0}}, sum};
      OP_SUB:  alu_res = {{DW{diff[DW-1]}}, diff};
      OP_MUL:  alu_res = {{DW{1'b0}}, a_q} * {{DW{1'b0}}, b_q};
      OP_AND:  alu_res = {{DW{1'b0}}, a_q & b_q};
      OP_OR:   alu_res = {{DW{1'b0}}, a_q | b_q};
      OP_XOR:  alu_res = {{DW{1'b0}}, a_q ^ b_q};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    hit_d      = hit_q;
    valid_d    = valid_q;
    fill_we    = 1'b0;
    line_wr    = 1'b0;
    line_wdata = mem_rdata;
    case (state_q)
      IDLE: if (start_op) state_d = (op_sel[2:1] == 2'b11) ? LOOKUP : EXEC;
      EXEC: begin
        result_d = alu_res;
        state_d  = DONE;
      end
      LOOKUP: begin
        hit_d = lookup_hit;
        if (op_q == OP_LOAD && lookup_hit) begin
          result_d = {{DW{1'b0}}, data_mem[idx]};
          state_d  = DONE;
        end else begin
          state_d = ARB;
        end
      end
      ARB: if (gnt_arb) state_d = BUS;
      BUS: if (mem_ack) begin
        state_d = DONE;
        if (op_q == OP_LOAD) begin
          fill_we      = 1'b1;
          line_wr      = 1'b1;
          valid_d[idx] = 1'b1;
          result_d     = {{DW{1'b0}}, mem_rdata};
        end else begin
          // write-through; only a line that already holds this address is refreshed
          line_wr    = hit_q;
          line_wdata = wdata_q;
          result_d   = '0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      hit_q    <= 1'b0;
      valid_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hit_q    <= hit_d;
      valid_q  <= valid_d;
      if (state_q == IDLE && start_op) begin
        a_q     <= A;
        b_q     <= B;
        op_q    <= op_sel;
        addr_q  <= address_in;
        wdata_q <= data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) tag_mem[idx] <= tag;
    if (line_wr) data_mem[idx] <= line_wdata;
  end

  assign req_arb   = (state_q == ARB) || (state_q == BUS);
  assign mem_req   = (state_q == BUS);
  assign mem_we    = (state_q == BUS) && (op_q == OP_STORE);
  assign mem_addr  = (state_q == BUS) ? addr_q : '0;
  assign mem_wdata = mem_we ? wdata_q : '0;
  assign end_op    = (state_q == DONE);
  assign result    = result_q;
  assign hit       = hit_q;

endmodule

// File: tb/tb_cpu_node.sv
// Directed bench for cpu_node: ALU ops, cache load/store paths, arbitration and
// reset abort, all against hand-computed values.
module tb_cpu_node;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  A = '0, B = '0, data_in = '0, mem_rdata = '0;
  logic        start_op = 1'b0, gnt_arb = 1'b0, mem_ack = 1'b0;
  logic [2:0]  op_sel = '0;
  logic [11:0] address_in = '0;
  logic        req_arb, mem_we, mem_req, end_op, hit;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [15:0] result;
  int checks = 0;
  int errors = 0;

  cpu_node #(.DW(8), .AW(12), .LW(4)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .start_op(start_op), .op_sel(op_sel),
    .address_in(address_in), .data_in(data_in), .req_arb(req_arb), .gnt_arb(gnt_arb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_req(mem_req),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .result(result), .end_op(end_op), .hit(hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start_op for one cycle; returns one negedge later (op accepted).
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [11:0] addr, input logic [7:0] d);
    op_sel = op; A = a; B = b; address_in = addr; data_in = d; start_op = 1'b1;
    @(negedge clk);
    start_op = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_result", result, 0);
    chk("rst_end_op", end_op, 0);
    chk("rst_hit", hit, 0);
    chk("rst_req_arb", req_arb, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // MUL FF*FF
    issue(3'd2, 8'hFF, 8'hFF, 12'h000, 8'h00);
    chk("mul_no_end_early", end_op, 0);
    @(negedge clk);
    chk("mul_end_op", end_op, 1);
    chk("mul_result", result, 16'hFE01);
    @(negedge clk);
    chk("mul_end_pulse", end_op, 0);

    // SUB 3-5
    issue(3'd1, 8'd3, 8'd5, 12'h000, 8'h00);
    @(negedge clk);
    chk("sub_end_op", end_op, 1);
    chk("sub_result", result, 16'hFFFE);
    @(negedge clk);

    // ADD carry and XOR
    issue(3'd0, 8'hF0, 8'h20, 12'h000, 8'h00);
    @(negedge clk);
    chk("add_result", result, 16'h0110);
    @(negedge clk);
    issue(3'd5, 8'hA5, 8'h0F, 12'h000, 8'h00);
    @(negedge clk);
    chk("xor_result", result, 16'h00AA);
    @(negedge clk);

    // LOAD 123 after reset: miss, grant after 3 cycles, ack with 5A
    issue(3'd6, 8'h00, 8'h00, 12'h123, 8'h00);
    chk("ld1_lookup_no_req", req_arb, 0);
    @(negedge clk);
    chk("ld1_hit", hit, 0);
    chk("ld1_req_arb", req_arb, 1);
    issue(3'd3, 8'hFF, 8'hFF, 12'h456, 8'h99);  // ignored outside IDLE
    chk("ld1_req_hold1", req_arb, 1);
    chk("ld1_no_bus1", mem_req, 0);
    @(negedge clk);
    chk("ld1_req_hold2", req_arb, 1);
    gnt_arb = 1'b1;
    @(negedge clk);
    gnt_arb = 1'b0;
    chk("ld1_mem_req", mem_req, 1);
    chk("ld1_mem_addr", mem_addr, 12'h123);
    chk("ld1_mem_we", mem_we, 0);
    chk("ld1_req_in_bus", req_arb, 1);
    @(negedge clk);
    chk("ld1_wait_ack", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 8'h5A;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("ld1_end_op", end_op, 1);
    chk("ld1_result", result, 16'h005A);
    chk("ld1_req_drop", req_arb, 0);
    chk("ld1_mem_req_drop", mem_req, 0);
    @(negedge clk);

    // repeat LOAD 123: hit, latency 2
    issue(3'd6, 8'h00, 8'h00, 12'h123, 8'h00);
    chk("ld2_no_req", req_arb, 0);
    @(negedge clk);
    chk("ld2_end_op", end_op, 1);
    chk("ld2_hit", hit, 1);
    chk("ld2_result", result, 16'h005A);
    chk("ld2_no_req_done", req_arb, 0);
    @(negedge clk);

    // STORE 123 C3 on valid line; ack present on BUS entry
    issue(3'd7, 8'h00, 8'h00, 12'h123, 8'hC3);
    @(negedge clk);
    chk("st_hit", hit, 1);
    chk("st_req_arb", req_arb, 1);
    gnt_arb = 1'b1; mem_ack = 1'b1;
    @(negedge clk);
    gnt_arb = 1'b0;
    chk("st_mem_we", mem_we, 1);
    chk("st_mem_wdata", mem_wdata, 8'hC3);
    chk("st_mem_addr", mem_addr, 12'h123);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("st_end_op", end_op, 1);
    chk("st_result", result, 0);
    @(negedge clk);
    issue(3'd6, 8'h00, 8'h00, 12'h123, 8'h00);
    @(negedge clk);
    chk("ld3_hit", hit, 1);
    chk("ld3_result", result, 16'h00C3);
    @(negedge clk);

    // STORE miss does not allocate
    issue(3'd7, 8'h00, 8'h00, 12'h456, 8'hAA);
    @(negedge clk);
    chk("stm_hit", hit, 0);
    gnt_arb = 1'b1; mem_ack = 1'b1;
    @(negedge clk);
    gnt_arb = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    issue(3'd6, 8'h00, 8'h00, 12'h456, 8'h00);
    @(negedge clk);
    chk("stm_no_alloc", hit, 0);
    gnt_arb = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h3C;
    @(negedge clk);
    gnt_arb = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stm_ld_result", result, 16'h003C);
    @(negedge clk);

    // LOAD 223 evicts 123
    issue(3'd6, 8'h00, 8'h00, 12'h223, 8'h00);
    @(negedge clk);
    chk("ld223_hit", hit, 0);
    gnt_arb = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h77;
    @(negedge clk);
    gnt_arb = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("ld223_result", result, 16'h0077);
    @(negedge clk);
    issue(3'd6, 8'h00, 8'h00, 12'h123, 8'h00);
    @(negedge clk);
    chk("ld123_evicted", hit, 0);
    chk("ld123_req", req_arb, 1);
    gnt_arb = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h11;
    @(negedge clk);
    gnt_arb = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("ld123_refill", result, 16'h0011);
    @(negedge clk);

    // reset during BUS aborts at once
    issue(3'd6, 8'h00, 8'h00, 12'h345, 8'h00);
    @(negedge clk);
    gnt_arb = 1'b1;
    @(negedge clk);
    gnt_arb = 1'b0;
    chk("abort_in_bus", mem_req, 1);
    #2 rst = 1'b0;
    #1;
    chk("abort_req_arb", req_arb, 0);
    chk("abort_mem_req", mem_req, 0);
    chk("abort_result", result, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(3'd6, 8'h00, 8'h00, 12'h345, 8'h00);
    @(negedge clk);
    chk("post_abort_miss", hit, 0);
    chk("post_abort_req", req_arb, 1);
    gnt_arb = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h42;
    @(negedge clk);
    gnt_arb = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("post_abort_result", result, 16'h0042);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
